// File: rtl/bus_seq_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for bus_sequencer.
// MUL/DIV classify as wide only when BUS_SEQ_HILO_EN is defined; otherwise they are illegal.
package bus_seq_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_AND = 4'd2;
  localparam logic [3:0] OP_OR  = 4'd3;
  localparam logic [3:0] OP_SHL = 4'd4;
  localparam logic [3:0] OP_SHR = 4'd5;
  localparam logic [3:0] OP_NOT = 4'd6;
  localparam logic [3:0] OP_NEG = 4'd7;
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam logic [3:0] OP_DIV = 4'd9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_T_A  = 3'd1;
  localparam logic [2:0] ST_T_B  = 3'd2;
  localparam logic [2:0] ST_T_C  = 3'd3;
  localparam logic [2:0] ST_T_D  = 3'd4;

  typedef enum logic [1:0] {
    CLS_BINARY  = 2'd0,
    CLS_UNARY   = 2'd1,
    CLS_WIDE    = 2'd2,
    CLS_ILLEGAL = 2'd3
  } op_class_t;

  function automatic op_class_t classify_op(input logic [3:0] op);
    op_class_t cls;
    cls = CLS_ILLEGAL;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR: cls = CLS_BINARY;
      OP_NOT, OP_NEG:                                cls = CLS_UNARY;
`ifdef BUS_SEQ_HILO_EN
      OP_MUL, OP_DIV:                                cls = CLS_WIDE;
`endif
      default:                                       cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/bus_seq_decode.sv
// Combinational opcode-to-class decode; any opcode wider than the defined 4-bit space is illegal.
// Honours BUS_SEQ_HILO_EN through bus_seq_pkg::classify_op.
module bus_seq_decode
  import bus_seq_pkg::*;
#(
  parameter int OPW = 4
) (
  input  logic [OPW-1:0] i_opcode,
  output op_class_t      o_op_class
);

  logic [31:0] w_op_ext;

  assign w_op_ext   = 32'(i_opcode);
  assign o_op_class = (w_op_ext > 32'd15) ? CLS_ILLEGAL : classify_op(w_op_ext[3:0]);

endmodule

// File: rtl/bus_sequencer.sv
// T-state micro-step controller for the phase-1 bus: one bus source per cycle plus Y/Z/rc loads.
// BUS_SEQ_HILO_EN adds the T_D high-half writeback for MUL/DIV and drives hi_load.
//
// state   | meaning
// IDLE    | no bus source enabled, ready for a new op
// T_A     | RAout + Yin (source A into Y)
// T_B     | RBout + Zin (source B through ALU into Z)
// T_C     | RZout low half, rc_load; final step unless wide op with HILO
// T_D     | RZout high half, hi_load; final step of a wide op
module bus_sequencer
  import bus_seq_pkg::*;
#(
  parameter int OPW  = 4,
  parameter int REGW = 4
) (
  input  logic            clock,
  input  logic            clear_n,
  input  logic            start,
  input  logic [OPW-1:0]  opcode,
  input  logic [REGW-1:0] ra_idx,
  input  logic [REGW-1:0] rb_idx,
  input  logic [REGW-1:0] rc_idx,
  output logic            ready,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic            RAout,
  output logic            RBout,
  output logic            RZout,
  output logic            Yin,
  output logic            Zin,
  output logic [OPW-1:0]  alu_op,
  output logic [REGW-1:0] rd_idx,
  output logic            rc_load,
  output logic [REGW-1:0] wr_idx,
  output logic            z_hi_sel,
  output logic            hi_load
);

  op_class_t       w_cls;
  logic            w_accept;

  logic [2:0]      r_state, n_state;
  logic            r_wide, n_wide;
  logic [OPW-1:0]  r_op, n_op;
  logic [REGW-1:0] r_ra, n_ra;
  logic [REGW-1:0] r_rb, n_rb;
  logic [REGW-1:0] r_rc, n_rc;
  logic            n_err_pulse;

  logic            r_ready, r_busy, r_done, r_err;
  logic            r_ra_out, r_rb_out, r_rz_out, r_yin, r_zin;
  logic            r_rc_load, r_z_hi_sel, r_hi_load;
  logic [REGW-1:0] r_rd_idx;

  logic            n_final;
  logic            n_ready, n_busy, n_done;
  logic            n_ra_out, n_rb_out, n_rz_out, n_yin, n_zin;
  logic            n_rc_load, n_z_hi_sel, n_hi_load;
  logic [REGW-1:0] n_rd_idx;

  bus_seq_decode #(.OPW(OPW)) u_decode (
    .i_opcode   (opcode),
    .o_op_class (w_cls)
  );

  assign w_accept = start && r_ready;

  always_comb begin
    n_state     = r_state;
    n_wide      = r_wide;
    n_op        = r_op;
    n_ra        = r_ra;
    n_rb        = r_rb;
    n_rc        = r_rc;
    n_err_pulse = 1'b0;
    if (w_accept) begin
      n_op   = opcode;
      n_ra   = ra_idx;
      n_rb   = rb_idx;
      n_rc   = rc_idx;
      n_wide = (w_cls == CLS_WIDE);
      case (w_cls)
        CLS_BINARY, CLS_WIDE: n_state = ST_T_A;
        CLS_UNARY:            n_state = ST_T_B;
        default: begin
          n_state     = ST_IDLE;
          n_err_pulse = 1'b1;
        end
      endcase
    end else begin
      case (r_state)
        ST_T_A: n_state = ST_T_B;
        ST_T_B: n_state = ST_T_C;
`ifdef BUS_SEQ_HILO_EN
        ST_T_C: n_state = r_wide ? ST_T_D : ST_IDLE;
`else
        ST_T_C: n_state = ST_IDLE;
`endif
        default: n_state = ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the next state and registered, so they are glitch-free state decodes.
  always_comb begin
    n_final    = ((n_state == ST_T_C) && !n_wide) || (n_state == ST_T_D);
    n_ready    = (n_state == ST_IDLE) || n_final;
    n_busy     = (n_state != ST_IDLE);
    n_done     = n_final;
    n_ra_out   = (n_state == ST_T_A);
    n_yin      = (n_state == ST_T_A);
    n_rb_out   = (n_state == ST_T_B);
    n_zin      = (n_state == ST_T_B);
    n_rz_out   = (n_state == ST_T_C) || (n_state == ST_T_D);
    n_rc_load  = (n_state == ST_T_C);
    n_z_hi_sel = (n_state == ST_T_D);
    n_hi_load  = (n_state == ST_T_D);
    n_rd_idx   = '0;
    if (n_state == ST_T_A) n_rd_idx = n_ra;
    else if (n_state == ST_T_B) n_rd_idx = n_rb;
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      r_state    <= ST_IDLE;
      r_wide     <= 1'b0;
      r_op       <= '0;
      r_ra       <= '0;
      r_rb       <= '0;
      r_rc       <= '0;
      r_ready    <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ra_out   <= 1'b0;
      r_rb_out   <= 1'b0;
      r_rz_out   <= 1'b0;
      r_yin      <= 1'b0;
      r_zin      <= 1'b0;
      r_rc_load  <= 1'b0;
      r_z_hi_sel <= 1'b0;
      r_hi_load  <= 1'b0;
      r_rd_idx   <= '0;
    end else begin
      r_state    <= n_state;
      r_wide     <= n_wide;
      r_op       <= n_op;
      r_ra       <= n_ra;
      r_rb       <= n_rb;
      r_rc       <= n_rc;
      r_ready    <= n_ready;
      r_busy     <= n_busy;
      r_done     <= n_done;
      r_err      <= n_err_pulse;
      r_ra_out   <= n_ra_out;
      r_rb_out   <= n_rb_out;
      r_rz_out   <= n_rz_out;
      r_yin      <= n_yin;
      r_zin      <= n_zin;
      r_rc_load  <= n_rc_load;
      r_z_hi_sel <= n_z_hi_sel;
      r_hi_load  <= n_hi_load;
      r_rd_idx   <= n_rd_idx;
    end
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign done     = r_done;
  assign err      = r_err;
  assign RAout    = r_ra_out;
  assign RBout    = r_rb_out;
  assign RZout    = r_rz_out;
  assign Yin      = r_yin;
  assign Zin      = r_zin;
  assign alu_op   = r_op;
  assign rd_idx   = r_rd_idx;
  assign rc_load  = r_rc_load;
  assign wr_idx   = r_rc;
  assign z_hi_sel = r_z_hi_sel;
`ifdef BUS_SEQ_HILO_EN
  assign hi_load  = r_hi_load;
`else
  assign hi_load  = 1'b0;
`endif

endmodule

// File: tb/tb_bus_sequencer.sv
// Self-checking bench for bus_sequencer: directed scenarios plus a randomized run against a step-list model.
// Follows BUS_SEQ_HILO_EN the same way the design does.
module tb_bus_sequencer;

  logic       clock = 1'b0;
  logic       clear_n;
  logic       start;
  logic [3:0] opcode, ra_idx, rb_idx, rc_idx;
  logic       ready, busy, done, err, RAout, RBout, RZout, Yin, Zin;
  logic       rc_load, z_hi_sel, hi_load;
  logic [3:0] alu_op, rd_idx, wr_idx;

  int errors = 0;
  int checks = 0;

  bus_sequencer #(.OPW(4), .REGW(4)) dut (
    .clock(clock), .clear_n(clear_n), .start(start), .opcode(opcode),
    .ra_idx(ra_idx), .rb_idx(rb_idx), .rc_idx(rc_idx),
    .ready(ready), .busy(busy), .done(done), .err(err),
    .RAout(RAout), .RBout(RBout), .RZout(RZout), .Yin(Yin), .Zin(Zin),
    .alu_op(alu_op), .rd_idx(rd_idx), .rc_load(rc_load), .wr_idx(wr_idx),
    .z_hi_sel(z_hi_sel), .hi_load(hi_load)
  );

  always #5 clock = ~clock;

  localparam logic [11:0] B_RA   = 12'h800;
  localparam logic [11:0] B_RB   = 12'h400;
  localparam logic [11:0] B_RZ   = 12'h200;
  localparam logic [11:0] B_YIN  = 12'h100;
  localparam logic [11:0] B_ZIN  = 12'h080;
  localparam logic [11:0] B_RCL  = 12'h040;
  localparam logic [11:0] B_ZHI  = 12'h020;
  localparam logic [11:0] B_HIL  = 12'h010;
  localparam logic [11:0] B_DONE = 12'h008;
  localparam logic [11:0] B_RDY  = 12'h004;
  localparam logic [11:0] B_BUSY = 12'h002;
  localparam logic [11:0] B_ERR  = 12'h001;

  wire [11:0] w_obs = {RAout, RBout, RZout, Yin, Zin, rc_load, z_hi_sel, hi_load,
                       done, ready, busy, err};

  always @(negedge clock) begin
    checks++;
    if ($countones({RAout, RBout, RZout}) > 1) begin
      errors++;
      $display("FAIL bus_mutex: RA/RB/RZ=%b%b%b at %0t, at most one high required",
               RAout, RBout, RZout, $time);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL reset_outputs: got %h want %h", w_obs, B_RDY); end
    checks++;
    if ({alu_op, rd_idx, wr_idx} !== 12'h000) begin
      errors++; $display("FAIL reset_indices: got %h want 000", {alu_op, rd_idx, wr_idx});
    end
    tick();
    clear_n = 1'b1;
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL reset_idle: got %h want %h", w_obs, B_RDY); end
    start = 1'b1; opcode = 4'd0; ra_idx = 4'd7; rb_idx = 4'd8; rc_idx = 4'd9;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY)) begin
      errors++; $display("FAIL reset_pre_tb: got %h want %h", w_obs, B_RB | B_ZIN | B_BUSY);
    end
    #2 clear_n = 1'b0;
    #1;
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL reset_abort: got %h want %h", w_obs, B_RDY); end
    #1 clear_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (w_obs !== B_RDY) begin
        errors++; $display("FAIL reset_after_abort[%0d]: got %h want %h", i, w_obs, B_RDY);
      end
    end
  endtask

  task automatic test_add();
    start = 1'b1; opcode = 4'd0; ra_idx = 4'd2; rb_idx = 4'd3; rc_idx = 4'd5;
    tick();
    start = 1'b0;
    checks++;
    if (w_obs !== (B_RA | B_YIN | B_BUSY) || rd_idx !== 4'd2) begin
      errors++; $display("FAIL add_c1: got %h rd=%0d want %h rd=2", w_obs, rd_idx, B_RA | B_YIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY) || rd_idx !== 4'd3 || alu_op !== 4'd0) begin
      errors++; $display("FAIL add_c2: got %h rd=%0d op=%0d want %h rd=3 op=0",
                         w_obs, rd_idx, alu_op, B_RB | B_ZIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY) || wr_idx !== 4'd5) begin
      errors++; $display("FAIL add_c3: got %h wr=%0d want %h wr=5",
                         w_obs, wr_idx, B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL add_c4: got %h want %h", w_obs, B_RDY); end
  endtask

  task automatic test_not();
    logic seen_ra = 1'b0;
    start = 1'b1; opcode = 4'd6; ra_idx = 4'd9; rb_idx = 4'd4; rc_idx = 4'd1;
    tick();
    start = 1'b0;
    seen_ra |= RAout;
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY) || rd_idx !== 4'd4) begin
      errors++; $display("FAIL not_c1: got %h rd=%0d want %h rd=4", w_obs, rd_idx, B_RB | B_ZIN | B_BUSY);
    end
    tick();
    seen_ra |= RAout;
    checks++;
    if (w_obs !== (B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY) || wr_idx !== 4'd1) begin
      errors++; $display("FAIL not_c2: got %h wr=%0d want %h wr=1",
                         w_obs, wr_idx, B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY);
    end
    tick();
    seen_ra |= RAout;
    checks++;
    if (seen_ra !== 1'b0) begin errors++; $display("FAIL not_no_raout: got RAout seen=%b want 0", seen_ra); end
  endtask

  task automatic test_back_to_back();
    start = 1'b1; opcode = 4'd1; ra_idx = 4'd1; rb_idx = 4'd2; rc_idx = 4'd3;
    tick();
    checks++;
    if (w_obs !== (B_RA | B_YIN | B_BUSY) || rd_idx !== 4'd1) begin
      errors++; $display("FAIL b2b_sub_ta: got %h rd=%0d want %h rd=1", w_obs, rd_idx, B_RA | B_YIN | B_BUSY);
    end
    opcode = 4'd3; ra_idx = 4'd4; rb_idx = 4'd5; rc_idx = 4'd6;
    tick();
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY) || alu_op !== 4'd1 || rd_idx !== 4'd2) begin
      errors++; $display("FAIL b2b_sub_tb: got %h op=%0d rd=%0d want %h op=1 rd=2",
                         w_obs, alu_op, rd_idx, B_RB | B_ZIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY) || wr_idx !== 4'd3) begin
      errors++; $display("FAIL b2b_sub_tc: got %h wr=%0d want %h wr=3",
                         w_obs, wr_idx, B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY);
    end
    tick();
    start = 1'b0;
    checks++;
    if (w_obs !== (B_RA | B_YIN | B_BUSY) || rd_idx !== 4'd4) begin
      errors++; $display("FAIL b2b_or_ta: got %h rd=%0d want %h rd=4", w_obs, rd_idx, B_RA | B_YIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY) || alu_op !== 4'd3 || rd_idx !== 4'd5) begin
      errors++; $display("FAIL b2b_or_tb: got %h op=%0d rd=%0d want %h op=3 rd=5",
                         w_obs, alu_op, rd_idx, B_RB | B_ZIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY) || wr_idx !== 4'd6) begin
      errors++; $display("FAIL b2b_or_tc: got %h wr=%0d want %h wr=6",
                         w_obs, wr_idx, B_RZ | B_RCL | B_DONE | B_RDY | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL b2b_idle: got %h want %h", w_obs, B_RDY); end
  endtask

  task automatic test_illegal();
    start = 1'b1; opcode = 4'd12; ra_idx = 4'd1; rb_idx = 4'd1; rc_idx = 4'd1;
    tick();
    start = 1'b0;
    checks++;
    if (w_obs !== (B_RDY | B_ERR)) begin errors++; $display("FAIL illegal_err: got %h want %h", w_obs, B_RDY | B_ERR); end
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL illegal_after: got %h want %h", w_obs, B_RDY); end
  endtask

  task automatic test_mul();
    start = 1'b1; opcode = 4'd8; ra_idx = 4'd10; rb_idx = 4'd11; rc_idx = 4'd12;
    tick();
    start = 1'b0;
`ifdef BUS_SEQ_HILO_EN
    checks++;
    if (w_obs !== (B_RA | B_YIN | B_BUSY)) begin errors++; $display("FAIL mul_ta: got %h want %h", w_obs, B_RA | B_YIN | B_BUSY); end
    tick();
    checks++;
    if (w_obs !== (B_RB | B_ZIN | B_BUSY) || alu_op !== 4'd8) begin
      errors++; $display("FAIL mul_tb: got %h op=%0d want %h op=8", w_obs, alu_op, B_RB | B_ZIN | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RZ | B_RCL | B_BUSY) || wr_idx !== 4'd12) begin
      errors++; $display("FAIL mul_tc: got %h wr=%0d want %h wr=12", w_obs, wr_idx, B_RZ | B_RCL | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== (B_RZ | B_ZHI | B_HIL | B_DONE | B_RDY | B_BUSY)) begin
      errors++; $display("FAIL mul_td: got %h want %h", w_obs, B_RZ | B_ZHI | B_HIL | B_DONE | B_RDY | B_BUSY);
    end
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL mul_idle: got %h want %h", w_obs, B_RDY); end
`else
    checks++;
    if (w_obs !== (B_RDY | B_ERR)) begin errors++; $display("FAIL mul_err: got %h want %h", w_obs, B_RDY | B_ERR); end
    tick();
    checks++;
    if (w_obs !== B_RDY) begin errors++; $display("FAIL mul_after: got %h want %h", w_obs, B_RDY); end
`endif
  endtask

  // Model: an accepted op becomes a list of bus steps; the head of the list is the current cycle.
  typedef struct packed {
    logic [2:0] kind;   // 1=A 2=B 3=C 4=D
    logic       fin;
  } step_t;

  task automatic test_random();
    step_t      q[$];
    step_t      s;
    logic [3:0] m_ra = '0, m_rb = '0, m_rc = '0, m_op = '0;
    logic       m_err = 1'b0;
    logic       m_ready, acc;
    logic [3:0] in_op, in_ra, in_rb, in_rc;
    logic [11:0] exp;
    start = 1'b0;
    tick();
    for (int i = 0; i < 600; i++) begin
      m_ready = (q.size() == 0) || q[0].fin;
      start  = ($urandom_range(0, 3) != 0);
      in_op  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      in_ra  = 4'($urandom_range(0, 15));
      in_rb  = 4'($urandom_range(0, 15));
      in_rc  = 4'($urandom_range(0, 15));
      opcode = in_op; ra_idx = in_ra; rb_idx = in_rb; rc_idx = in_rc;
      acc    = start && m_ready;
      tick();
      m_err = 1'b0;
      if (acc) begin
        m_op = in_op; m_ra = in_ra; m_rb = in_rb; m_rc = in_rc;
        q.delete();
        if (in_op <= 4'd5) begin
          q.push_back('{3'd1, 1'b0}); q.push_back('{3'd2, 1'b0}); q.push_back('{3'd3, 1'b1});
        end else if (in_op <= 4'd7) begin
          q.push_back('{3'd2, 1'b0}); q.push_back('{3'd3, 1'b1});
`ifdef BUS_SEQ_HILO_EN
        end else if (in_op <= 4'd9) begin
          q.push_back('{3'd1, 1'b0}); q.push_back('{3'd2, 1'b0});
          q.push_back('{3'd3, 1'b0}); q.push_back('{3'd4, 1'b1});
`endif
        end else begin
          m_err = 1'b1;
        end
      end else if (q.size() > 0) begin
        void'(q.pop_front());
      end
      if (q.size() == 0) begin
        s   = '{3'd0, 1'b0};
        exp = B_RDY | (m_err ? B_ERR : 12'h000);
      end else begin
        s   = q[0];
        exp = B_BUSY;
        case (s.kind)
          3'd1:    exp |= B_RA | B_YIN;
          3'd2:    exp |= B_RB | B_ZIN;
          3'd3:    exp |= B_RZ | B_RCL;
          default: exp |= B_RZ | B_ZHI | B_HIL;
        endcase
        if (s.fin) exp |= B_DONE | B_RDY;
      end
      checks++;
      if (w_obs !== exp) begin
        errors++; $display("FAIL rand_outputs[%0d]: got %h want %h (op=%0d)", i, w_obs, exp, m_op);
      end
      if (s.kind == 3'd1) begin
        checks++;
        if (rd_idx !== m_ra) begin errors++; $display("FAIL rand_rd_a[%0d]: got %0d want %0d", i, rd_idx, m_ra); end
      end else if (s.kind == 3'd2) begin
        checks++;
        if (rd_idx !== m_rb || alu_op !== m_op) begin
          errors++; $display("FAIL rand_rd_b[%0d]: got rd=%0d op=%0d want rd=%0d op=%0d",
                             i, rd_idx, alu_op, m_rb, m_op);
        end
      end else if (s.kind == 3'd3) begin
        checks++;
        if (wr_idx !== m_rc) begin errors++; $display("FAIL rand_wr[%0d]: got %0d want %0d", i, wr_idx, m_rc); end
      end
    end
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
  endtask

  initial begin
    clear_n = 1'b1;
    start   = 1'b0;
    opcode  = '0; ra_idx = '0; rb_idx = '0; rc_idx = '0;
    #1 clear_n = 1'b0;
    test_reset();
    test_add();
    test_not();
    test_back_to_back();
    test_illegal();
    test_mul();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
